// File: rtl/chan_accum_sat.sv
// chan_accum_sat: per-channel block accumulator, DEPTH samples per result.
// Ports: clk, rst_n, clear, in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_ovf.
module chan_accum_sat #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int OUT_W    = WIDTH + 2,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data [CHANNELS],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data [CHANNELS],
  output logic [CHANNELS-1:0]     out_ovf
);

  localparam int ACC_W = WIDTH + $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(DEPTH);
  // one guard bit above both widths so range compares are exact
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [EXT_W-1:0] SMAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SMIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc     [CHANNELS];
  logic signed [ACC_W-1:0] sum     [CHANNELS];
  logic signed [EXT_W-1:0] sum_ext [CHANNELS];
  logic signed [OUT_W-1:0] res     [CHANNELS];
  logic [CHANNELS-1:0]     hi;
  logic [CHANNELS-1:0]     lo;

  logic in_hs;
  logic out_hs;
  logic last;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign last   = (cnt == CNT_W'(DEPTH - 1));

  always_comb begin
    sum     = '{default: '0};
    sum_ext = '{default: '0};
    res     = '{default: '0};
    hi      = '0;
    lo      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = acc[i] +
        {{(ACC_W-WIDTH){in_data[i][WIDTH-1]}}, in_data[i]};
      sum_ext[i] =
        {{(EXT_W-ACC_W){sum[i][ACC_W-1]}}, sum[i]};
      hi[i] = (sum_ext[i] > SMAX);
      lo[i] = (sum_ext[i] < SMIN);
      if (SATURATE != 0 && hi[i])
        res[i] = SMAX[OUT_W-1:0];
      else if (SATURATE != 0 && lo[i])
        res[i] = SMIN[OUT_W-1:0];
      else
        res[i] = sum_ext[i][OUT_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_hs && last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
    if (clear) state_nxt = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // counter parks at DEPTH-1 in HOLD; only the output handshake rewinds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '{default: '0};
    end else if (clear || out_hs) begin
      cnt <= '0;
      acc <= '{default: '0};
    end else if (in_hs) begin
      acc <= sum;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '{default: '0};
      out_ovf  <= '0;
    end else if (!clear && in_hs && last) begin
      out_data <= res;
      out_ovf  <= hi | lo;
    end
  end

endmodule

// File: tb/tb_chan_accum_sat.sv
// tb_chan_accum_sat: directed checks of chan_accum_sat, sat and wrap instances.
// Ports: none; drives both instances from shared stimulus.
module tb_chan_accum_sat;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic out_ready;
  logic signed [7:0] in_data [2];

  logic              s_in_ready, s_out_valid;
  logic signed [8:0] s_out_data [2];
  logic [1:0]        s_out_ovf;
  logic              w_in_ready, w_out_valid;
  logic signed [8:0] w_out_data [2];
  logic [1:0]        w_out_ovf;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  chan_accum_sat #(
    .WIDTH(8), .CHANNELS(2), .DEPTH(4), .OUT_W(9), .SATURATE(1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf)
  );

  chan_accum_sat #(
    .WIDTH(8), .CHANNELS(2), .DEPTH(4), .OUT_W(9), .SATURATE(0)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .out_ovf(w_out_ovf)
  );

  task automatic check(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b);
    in_valid   = 1'b1;
    in_data[0] = 8'(a);
    in_data[1] = 8'(b);
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_data[0] = '0;
    in_data[1] = '0;
    #1;
    check("rst_in_ready", 32'(s_in_ready), 1);
    check("rst_out_valid", 32'(s_out_valid), 0);
    check("rst_data0", s_out_data[0], 0);
    check("rst_ovf", 32'(s_out_ovf), 0);
    #11 rst_n = 1'b1;

    // block 1: {10,-3} with one idle cycle mid-block
    send(10, -3);
    send(10, -3);
    tick();
    send(10, -3);
    check("b1_not_early", 32'(s_out_valid), 0);
    send(10, -3);
    check("b1_valid", 32'(s_out_valid), 1);
    check("b1_in_ready", 32'(s_in_ready), 0);
    check("b1_d0", s_out_data[0], 40);
    check("b1_d1", s_out_data[1], -12);
    check("b1_ovf", 32'(s_out_ovf), 0);
    check("b1_wrap_d1", w_out_data[1], -12);
    pop();
    check("b1_pop_valid", 32'(s_out_valid), 0);
    check("b1_pop_ready", 32'(s_in_ready), 1);

    // block 2: extremes, saturated and wrapped
    for (int k = 0; k < 4; k++) send(127, -128);
    check("b2_sat_d0", s_out_data[0], 255);
    check("b2_sat_d1", s_out_data[1], -256);
    check("b2_sat_ovf", 32'(s_out_ovf), 3);
    check("b2_wrap_d0", w_out_data[0], -4);
    check("b2_wrap_d1", w_out_data[1], 0);
    check("b2_wrap_ovf", 32'(w_out_ovf), 3);

    // hold with back-pressure while inputs are offered
    in_valid   = 1'b1;
    in_data[0] = 8'sd5;
    in_data[1] = 8'sd5;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_in_ready", 32'(s_in_ready), 0);
      check("hold_valid", 32'(s_out_valid), 1);
      check("hold_d0", s_out_data[0], 255);
      check("hold_ovf", 32'(s_out_ovf), 3);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rel_in_ready", 32'(s_in_ready), 1);
    for (int k = 0; k < 4; k++) tick();
    in_valid = 1'b0;
    check("b3_valid", 32'(s_out_valid), 1);
    check("b3_d0", s_out_data[0], 20);
    check("b3_d1", s_out_data[1], 20);
    check("b3_ovf", 32'(s_out_ovf), 0);
    pop();

    // clear after two samples, clear beats a simultaneous input
    send(7, 7);
    send(7, 7);
    clear = 1'b1;
    send(9, 9);
    clear = 1'b0;
    for (int k = 0; k < 3; k++) send(1, 1);
    check("clr_not_early", 32'(s_out_valid), 0);
    send(1, 1);
    check("clr_valid", 32'(s_out_valid), 1);
    check("clr_d0", s_out_data[0], 4);
    check("clr_d1", s_out_data[1], 4);

    // clear in HOLD drops the held result
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_hold_valid", 32'(s_out_valid), 0);
    check("clr_hold_ready", 32'(s_in_ready), 1);

    // async reset while holding a result
    for (int k = 0; k < 4; k++) send(2, 3);
    check("r_pre_valid", 32'(s_out_valid), 1);
    check("r_pre_d1", s_out_data[1], 12);
    #1 rst_n = 1'b0;
    #1;
    check("r_valid", 32'(s_out_valid), 0);
    check("r_in_ready", 32'(s_in_ready), 1);
    check("r_d1", s_out_data[1], 0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) send(-1, -2);
    check("r_post_valid", 32'(s_out_valid), 1);
    check("r_post_d0", s_out_data[0], -4);
    check("r_post_d1", s_out_data[1], -8);
    check("r_post_ovf", 32'(s_out_ovf), 0);
    pop();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
